// File: rtl/key_pio_debounce.sv
// Debounced pushbutton PIO with per-channel edge capture and maskable irq.
// Four-word Avalon-MM slave with registered one-cycle read latency.
module key_pio_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk_0,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_CAP  = 2'd2;
    localparam logic [1:0] ADDR_SEL  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pin_level;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] press_evt;
    logic [WIDTH-1:0] release_evt;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_word;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    // Internal polarity: 1 always means pressed.
    assign pin_level = in_port ^ {WIDTH{ACTIVE_LOW}};

    always_ff @(posedge clk_0) begin
        if (reset) begin
            sync_meta  <= '0;
            sync_level <= '0;
        end else begin
            sync_meta  <= pin_level;
            sync_level <= sync_meta;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             state;

        // Any return to the stable level restarts the count.
        always_ff @(posedge clk_0) begin
            if (reset) begin
                cnt   <= '0;
                state <= 1'b0;
            end else if (sync_level[i] == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                state <= sync_level[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = state;
    end

    always_ff @(posedge clk_0) begin
        if (reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign press_evt   = stable & ~stable_d;
    assign release_evt = ~stable & stable_d;
    assign cap_set     = (press_evt & ~edge_sel) | (release_evt & edge_sel);

    assign wr_en        = chipselect & write;
    assign rd_en        = chipselect & read;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        cap_clr = '0;
        if (wr_en && address == ADDR_CAP) begin
            cap_clr = wdata;
        end
    end

    always_ff @(posedge clk_0) begin
        if (reset) begin
            irq_mask <= '0;
            edge_sel <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= wdata;
            end
            if (wr_en && address == ADDR_SEL) begin
                edge_sel <= wdata;
            end
            // A new event outranks a same-cycle clear.
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (address)
            ADDR_DATA: rd_word[WIDTH-1:0] = stable;
            ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
            ADDR_CAP:  rd_word[WIDTH-1:0] = edge_cap;
            ADDR_SEL:  rd_word[WIDTH-1:0] = edge_sel;
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_word;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_key_pio_debounce.sv
// Bench for key_pio_debounce: register table, debounce timing, capture, irq.
// Read expectations are queued when issued and checked when readdata updates.
module tb_key_pio_debounce;

    logic        clk_0 = 1'b0;
    logic        reset;
    logic [2:0]  in_port;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } reg_vec_t;

    reg_vec_t vecs[7];

    key_pio_debounce #(
        .WIDTH(3),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_0(clk_0),
        .reset(reset),
        .in_port(in_port),
        .chipselect(chipselect),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk_0 = ~clk_0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare readdata just after the edge that loads it.
    always @(posedge clk_0) begin
        if (chipselect && read && !reset) begin
            logic [1:0] a;
            a = address;
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read a%0d: no expected value queued", a);
            end else begin
                check($sformatf("read a%0d", a), readdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk_0);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk_0);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic rd(logic [1:0] a, logic [31:0] e);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        exp_q.push_back(e);
        @(negedge clk_0);
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic rdwr(logic [1:0] a, logic [31:0] d, logic [31:0] e);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        exp_q.push_back(e);
        @(negedge clk_0);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd1, 32'hFFFF_FFF0, 32'h0};
        vecs[1] = '{2'd3, 32'h0000_0005, 32'h5};
        vecs[2] = '{2'd3, 32'hFFFF_FFFA, 32'h2};
        vecs[3] = '{2'd3, 32'h0000_0000, 32'h0};
        vecs[4] = '{2'd0, 32'h0000_0007, 32'h0};
        vecs[5] = '{2'd2, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{2'd1, 32'h0000_0000, 32'h0};

        reset      = 1'b1;
        in_port    = 3'b111;
        chipselect = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        idle(3);
        reset = 1'b0;

        for (int a = 0; a < 4; a++) rd(a[1:0], 32'h0);
        check("irq after reset", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].rexp);
        end
        rdwr(2'd1, 32'h5, 32'h0);
        rd(2'd1, 32'h5);
        wr(2'd1, 32'h0);
        check("irq after table", {31'b0, irq}, 32'h0);

        // Clean press of key1: S set on edge 6, visible in a read at edge 7.
        in_port[1] = 1'b0;
        for (int k = 1; k <= 7; k++) rd(2'd0, (k >= 7) ? 32'h2 : 32'h0);
        rd(2'd2, 32'h2);
        check("irq masked press", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h7);
        rd(2'd2, 32'h0);

        // Bounce on key0: low 3, high 1, then low.
        for (int k = 1; k <= 12; k++) begin
            in_port[0] = (k == 4);
            rd(2'd0, {29'b0, 1'b0, 1'b1, (k >= 11)});
        end
        rd(2'd2, 32'h1);

        // Interrupt path.
        in_port[1] = 1'b1;
        idle(8);
        wr(2'd2, 32'h7);
        wr(2'd1, 32'h2);
        check("irq before press", {31'b0, irq}, 32'h0);
        in_port[1] = 1'b0;
        idle(8);
        check("irq on press", {31'b0, irq}, 32'h1);
        rd(2'd2, 32'h2);
        wr(2'd2, 32'h1);
        check("irq other clear", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h2);
        check("irq cleared", {31'b0, irq}, 32'h0);

        // Release select on key2.
        wr(2'd3, 32'h4);
        wr(2'd2, 32'h7);
        in_port[2] = 1'b0;
        idle(8);
        rd(2'd2, 32'h0);
        in_port[2] = 1'b1;
        idle(8);
        rd(2'd2, 32'h4);
        wr(2'd3, 32'h0);
        rd(2'd2, 32'h4);
        wr(2'd3, 32'h4);
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h0);
        in_port[2] = 1'b0;
        idle(8);
        rd(2'd2, 32'h0);
        // Release event lands on edge 7, same edge as the clear write.
        in_port[2] = 1'b1;
        idle(6);
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h4);
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h0);
        check("irq sel path", {31'b0, irq}, 32'h0);

        // Reset in the middle of a key0 debounce.
        in_port[0] = 1'b1;
        idle(8);
        wr(2'd2, 32'h7);
        in_port[0] = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("irq after mid reset", {31'b0, irq}, 32'h0);
        for (int k = 1; k <= 8; k++) rd(2'd0, (k >= 7) ? 32'h3 : 32'h0);
        rd(2'd2, 32'h3);
        rd(2'd1, 32'h0);
        rd(2'd3, 32'h0);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) idle(1);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
